// File: rtl/stage_4_output_scheduler.sv
// ---------------------------------------------------------------------------
// stage_4_output_scheduler
//
// Sequencer and byte scheduler around the stage-4 carry/final-bits path.
// Sequences the first/final control flags that stage 4 needs. Collects the
// 0-4 bytes stage 4 produces each cycle into a circular byte FIFO. Drains one
// byte per cycle to the bitstream sink.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   start             pulse, begins a frame (only honoured in IDLE)
//   in_sym_valid      a symbol enters the encoder this cycle
//   in_end            pulse, previous symbol was the last of the frame
//   in_byte_1..3      carry-propagation bytes, in_byte_1 oldest
//   in_byte_cnt       number of valid bytes among in_byte_1..3
//   in_last_byte      trailing byte, valid only with in_flag_last
//   in_flag_last      stage 4 emitted its final bytes this cycle
//   in_carry_error    stage 4 confirmed a carry error
//   out_flag_first    stage 4 flag_first
//   out_final_2_3     stage 4 final_flag_2_3 (final-bit latch enable)
//   out_final         stage 4 final_flag (final-bit mux select)
//   out_stall         hold the encoder pipeline (fewer than 4 free slots)
//   m_data/m_valid/m_ready/m_last   byte stream to the sink
//   done              one-cycle pulse when the frame is fully drained
//   err_overflow/err_carry/err_timeout   sticky until the next start
//   dbg_state         current FSM state (0 = IDLE)
//   dbg_count         current FIFO occupancy
//
// Handshake: a byte moves from m_data to the sink on every rising clk edge
// where m_valid && m_ready. m_valid depends only on FIFO occupancy, never on
// m_ready, and m_data is stable while m_valid is high and m_ready is low.
// ---------------------------------------------------------------------------
module stage_4_output_scheduler #(
   parameter int BYTE_WIDTH      = 8,
   parameter int FIFO_ADDR_WIDTH = 4,
   parameter int LAST_TIMEOUT    = 15
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic                       in_sym_valid,
   input  logic                       in_end,
   input  logic [BYTE_WIDTH-1:0]      in_byte_1,
   input  logic [BYTE_WIDTH-1:0]      in_byte_2,
   input  logic [BYTE_WIDTH-1:0]      in_byte_3,
   input  logic [1:0]                 in_byte_cnt,
   input  logic [BYTE_WIDTH-1:0]      in_last_byte,
   input  logic                       in_flag_last,
   input  logic                       in_carry_error,
   output logic                       out_flag_first,
   output logic                       out_final_2_3,
   output logic                       out_final,
   output logic                       out_stall,
   output logic [BYTE_WIDTH-1:0]      m_data,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic                       m_last,
   output logic                       done,
   output logic                       err_overflow,
   output logic                       err_carry,
   output logic                       err_timeout,
   output logic [2:0]                 dbg_state,
   output logic [FIFO_ADDR_WIDTH:0]   dbg_count
);

   localparam int AW    = FIFO_ADDR_WIDTH;
   localparam int CW    = FIFO_ADDR_WIDTH + 1;
   localparam int DEPTH = 1 << FIFO_ADDR_WIDTH;
   localparam int TW    = (LAST_TIMEOUT > 1) ? $clog2(LAST_TIMEOUT) : 1;

   localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
   localparam logic [TW-1:0] TIMER_LAST = TW'(LAST_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_RUN       = 3'd1,
      S_FIN_A     = 3'd2,
      S_FIN_B     = 3'd3,
      S_WAIT_LAST = 3'd4,
      S_DRAIN     = 3'd5,
      S_DONE      = 3'd6
   } state_t;

   state_t                state_q, state_d;
   logic [AW-1:0]         rd_q, rd_d;
   logic [AW-1:0]         wr_q, wr_d;
   logic [CW-1:0]         count_q, count_d;
   logic [TW-1:0]         timer_q, timer_d;
   logic                  first_seen_q, first_seen_d;
   logic                  err_ovf_q, err_ovf_d;
   logic                  err_carry_q, err_carry_d;
   logic                  err_tmo_q, err_tmo_d;
   logic [BYTE_WIDTH-1:0] mem_q [DEPTH];

   logic                  pushing;
   logic                  pop;
   logic [2:0]            push_n;
   logic [2:0]            accept_n;
   logic [CW-1:0]         space;
   logic                  overflow_now;
   logic                  clear_frame;
   logic                  timeout_now;
   logic [BYTE_WIDTH-1:0] push_bytes [4];

   // ---------------- FIFO datapath ----------------
   always_comb begin
      pushing = (state_q == S_RUN) || (state_q == S_FIN_A) ||
                (state_q == S_FIN_B) || (state_q == S_WAIT_LAST);
      pop     = m_valid && m_ready;
      push_n  = pushing ? ({1'b0, in_byte_cnt} + {2'b00, in_flag_last}) : 3'd0;

      // Bytes are packed oldest-first; the trailing byte lands right after
      // the carry bytes, whichever slot that is.
      push_bytes[0] = in_byte_1;
      push_bytes[1] = in_byte_2;
      push_bytes[2] = in_byte_3;
      push_bytes[3] = in_last_byte;
      push_bytes[in_byte_cnt] = in_last_byte;

      // A same-cycle pop frees its slot for this cycle's push.
      space = DEPTH_C - count_q + CW'(pop);
      if (CW'(push_n) > space) begin
         accept_n     = space[2:0];
         overflow_now = 1'b1;
      end else begin
         accept_n     = push_n;
         overflow_now = 1'b0;
      end

      count_d = count_q + CW'(accept_n) - CW'(pop);
      rd_d    = rd_q + AW'(pop);
      wr_d    = wr_q + AW'(accept_n);
   end

   always_ff @(posedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (3'(k) < accept_n) begin
            mem_q[wr_q + AW'(k)] <= push_bytes[k];
         end
      end
   end

   // ---------------- FSM next state ----------------
   always_comb begin
      state_d      = state_q;
      timer_d      = timer_q;
      first_seen_d = first_seen_q;
      clear_frame  = 1'b0;
      timeout_now  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d      = S_RUN;
               first_seen_d = 1'b0;
               clear_frame  = 1'b1;
            end
         end
         S_RUN: begin
            if (in_sym_valid) first_seen_d = 1'b1;
            // in_flag_last here is a protocol error: bytes go in, state holds.
            if (in_end) state_d = S_FIN_A;
         end
         S_FIN_A: state_d = S_FIN_B;
         S_FIN_B: begin
            state_d = S_WAIT_LAST;
            timer_d = '0;
         end
         S_WAIT_LAST: begin
            // timer_q counts WAIT_LAST cycles already spent, so the force
            // happens after exactly LAST_TIMEOUT cycles without in_flag_last.
            if (in_flag_last) begin
               state_d = S_DRAIN;
            end else if (timer_q == TIMER_LAST) begin
               state_d     = S_DRAIN;
               timeout_now = 1'b1;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         S_DRAIN: begin
            if (count_q == '0) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      err_ovf_d   = clear_frame ? 1'b0 : (err_ovf_q | overflow_now);
      err_carry_d = clear_frame ? 1'b0 :
                    (err_carry_q | (in_carry_error && (state_q != S_IDLE)));
      err_tmo_d   = clear_frame ? 1'b0 : (err_tmo_q | timeout_now);
   end

   // ---------------- state registers ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         rd_q         <= '0;
         wr_q         <= '0;
         count_q      <= '0;
         timer_q      <= '0;
         first_seen_q <= 1'b0;
         err_ovf_q    <= 1'b0;
         err_carry_q  <= 1'b0;
         err_tmo_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         first_seen_q <= first_seen_d;
         err_ovf_q    <= err_ovf_d;
         err_carry_q  <= err_carry_d;
         err_tmo_q    <= err_tmo_d;
         if (clear_frame) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
         end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
         end
      end
   end

   // ---------------- outputs ----------------
   always_comb begin
      m_valid        = (count_q != '0);
      m_data         = m_valid ? mem_q[rd_q] : '0;
      m_last         = m_valid && (state_q == S_DRAIN) && (count_q == CW'(1));
      out_flag_first = (state_q == S_RUN) && in_sym_valid && !first_seen_q;
      out_final_2_3  = (state_q == S_FIN_A);
      out_final      = (state_q == S_FIN_B);
      out_stall      = (state_q != S_IDLE) && (state_q != S_DONE) &&
                       ((DEPTH_C - count_q) < CW'(4));
      done           = (state_q == S_DONE);
      err_overflow   = err_ovf_q;
      err_carry      = err_carry_q;
      err_timeout    = err_tmo_q;
      dbg_state      = state_q;
      dbg_count      = count_q;
   end

endmodule

// File: tb/tb_stage_4_output_scheduler.sv
module tb_stage_4_output_scheduler;

   localparam int DEPTH = 16;
   localparam int LT    = 15;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, start, in_sym_valid, in_end, in_flag_last, in_carry_error;
   logic [7:0] in_byte_1, in_byte_2, in_byte_3, in_last_byte;
   logic [1:0] in_byte_cnt;
   logic       out_flag_first, out_final_2_3, out_final, out_stall;
   logic [7:0] m_data;
   logic       m_valid, m_ready, m_last, done;
   logic       err_overflow, err_carry, err_timeout;
   logic [2:0] dbg_state;
   logic [4:0] dbg_count;

   stage_4_output_scheduler #(
      .BYTE_WIDTH(8), .FIFO_ADDR_WIDTH(4), .LAST_TIMEOUT(LT)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .in_sym_valid(in_sym_valid),
      .in_end(in_end), .in_byte_1(in_byte_1), .in_byte_2(in_byte_2),
      .in_byte_3(in_byte_3), .in_byte_cnt(in_byte_cnt), .in_last_byte(in_last_byte),
      .in_flag_last(in_flag_last), .in_carry_error(in_carry_error),
      .out_flag_first(out_flag_first), .out_final_2_3(out_final_2_3),
      .out_final(out_final), .out_stall(out_stall), .m_data(m_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .done(done),
      .err_overflow(err_overflow), .err_carry(err_carry), .err_timeout(err_timeout),
      .dbg_state(dbg_state), .dbg_count(dbg_count)
   );

   typedef struct packed {
      logic       rst, start, sym, fend, flag_last, carry, rdy;
      logic [1:0] cnt;
      logic [7:0] b1, b2, b3, lb;
   } stim_t;

   typedef struct packed {
      logic       valid, last, first, f23, fin, stall, done, ovf, carry, tmo;
      logic [7:0] data;
      logic [4:0] count;
      logic [2:0] state;
   } obs_t;

   typedef struct packed {
      stim_t      s;
      logic       e_valid;
      logic [7:0] e_data;
      logic       e_last, e_first, e_f23, e_fin, e_done;
   } vec_t;

   // ---------------- counters / checks ----------------
   int n_checks = 0;
   int n_fail   = 0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] want);
      n_checks++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, want);
      end
   endfunction

   // ---------------- reference model (scoreboard) ----------------
   typedef enum {P_IDLE, P_RUN, P_FIN_A, P_FIN_B, P_WAIT, P_DRAIN, P_DONE} phase_t;
   phase_t     ph = P_IDLE;
   logic [7:0] exp_q[$];
   bit         model_valid = 0;
   bit         first_seen, e_ovf, e_carry, e_tmo;
   int         wait_cycles;

   task automatic model_check(input stim_t s, input obs_t o);
      bit ev;
      if (model_valid) begin
         ev = (exp_q.size() != 0);
         chk("m_valid", 32'(o.valid), 32'(ev));
         if (ev) chk("m_data", 32'(o.data), 32'(exp_q[0]));
         chk("m_last", 32'(o.last), 32'(ev && ph == P_DRAIN && exp_q.size() == 1));
         chk("flag_first", 32'(o.first), 32'(ph == P_RUN && s.sym && !first_seen));
         chk("final_2_3", 32'(o.f23), 32'(ph == P_FIN_A));
         chk("final", 32'(o.fin), 32'(ph == P_FIN_B));
         chk("stall", 32'(o.stall),
             32'(ph != P_IDLE && ph != P_DONE && (DEPTH - exp_q.size()) < 4));
         chk("done", 32'(o.done), 32'(ph == P_DONE));
         chk("err_overflow", 32'(o.ovf), 32'(e_ovf));
         chk("err_carry", 32'(o.carry), 32'(e_carry));
         chk("err_timeout", 32'(o.tmo), 32'(e_tmo));
         chk("count", 32'(o.count), 32'(exp_q.size()));
         chk("dbg_idle", 32'(o.state == 3'd0), 32'(ph == P_IDLE));
      end
   endtask

   task automatic model_update(input stim_t s);
      int         pre;
      logic [7:0] nb[$];
      if (s.rst) begin
         ph = P_IDLE;
         exp_q.delete();
         first_seen = 0; e_ovf = 0; e_carry = 0; e_tmo = 0; wait_cycles = 0;
         model_valid = 1;
      end else begin
         pre = exp_q.size();
         if (pre != 0 && s.rdy) void'(exp_q.pop_front());
         if (ph == P_RUN || ph == P_FIN_A || ph == P_FIN_B || ph == P_WAIT) begin
            if (s.cnt >= 1) nb.push_back(s.b1);
            if (s.cnt >= 2) nb.push_back(s.b2);
            if (s.cnt >= 3) nb.push_back(s.b3);
            if (s.flag_last) nb.push_back(s.lb);
            foreach (nb[i]) begin
               if (exp_q.size() < DEPTH) exp_q.push_back(nb[i]);
               else e_ovf = 1;
            end
         end
         if (ph != P_IDLE && s.carry) e_carry = 1;
         case (ph)
            P_IDLE:  if (s.start) begin
                        ph = P_RUN; first_seen = 0;
                        e_ovf = 0; e_carry = 0; e_tmo = 0; exp_q.delete();
                     end
            P_RUN:   begin
                        if (s.sym) first_seen = 1;
                        if (s.fend) ph = P_FIN_A;
                     end
            P_FIN_A: ph = P_FIN_B;
            P_FIN_B: begin ph = P_WAIT; wait_cycles = 0; end
            P_WAIT:  begin
                        wait_cycles++;
                        if (s.flag_last) ph = P_DRAIN;
                        else if (wait_cycles == LT) begin ph = P_DRAIN; e_tmo = 1; end
                     end
            P_DRAIN: if (pre == 0) ph = P_DONE;
            P_DONE:  ph = P_IDLE;
            default: ph = P_IDLE;
         endcase
      end
   endtask

   // ---------------- driver ----------------
   task automatic step(input stim_t s, output obs_t o);
      @(negedge clk);
      reset = s.rst; start = s.start; in_sym_valid = s.sym; in_end = s.fend;
      in_byte_cnt = s.cnt; in_byte_1 = s.b1; in_byte_2 = s.b2; in_byte_3 = s.b3;
      in_last_byte = s.lb; in_flag_last = s.flag_last; in_carry_error = s.carry;
      m_ready = s.rdy;
      #2;
      o.valid = m_valid; o.last = m_last; o.first = out_flag_first;
      o.f23 = out_final_2_3; o.fin = out_final; o.stall = out_stall; o.done = done;
      o.ovf = err_overflow; o.carry = err_carry; o.tmo = err_timeout;
      o.data = m_data; o.count = dbg_count; o.state = dbg_state;
      model_check(s, o);
      @(posedge clk);
      model_update(s);
   endtask

   function automatic stim_t idle_s(input logic rdy);
      stim_t s;
      s = '0;
      s.rdy = rdy;
      return s;
   endfunction

   function automatic stim_t push_s(input logic [1:0] cnt, input logic [7:0] b1, b2, b3,
                                    input logic rdy);
      stim_t s;
      s = idle_s(rdy);
      s.cnt = cnt; s.b1 = b1; s.b2 = b2; s.b3 = b3;
      return s;
   endfunction

   function automatic stim_t st(input logic start_v, sym, fend, input logic [1:0] cnt,
                                input logic [7:0] b1, b2, input logic fl,
                                input logic [7:0] lb, input logic rdy);
      stim_t s;
      s = push_s(cnt, b1, b2, 8'h00, rdy);
      s.start = start_v; s.sym = sym; s.fend = fend; s.flag_last = fl; s.lb = lb;
      return s;
   endfunction

   function automatic vec_t vv(input stim_t s, input logic v, input logic [7:0] d,
                               input logic l, ff, f23, fin, dn);
      vec_t t;
      t.s = s; t.e_valid = v; t.e_data = d; t.e_last = l;
      t.e_first = ff; t.e_f23 = f23; t.e_fin = fin; t.e_done = dn;
      return t;
   endfunction

   function automatic stim_t rand_s();
      stim_t s;
      s = '0;
      s.cnt   = 2'($urandom_range(0, 3));
      s.b1    = 8'($urandom); s.b2 = 8'($urandom);
      s.b3    = 8'($urandom); s.lb = 8'($urandom);
      s.rdy   = ($urandom_range(0, 2) != 0);
      s.carry = ($urandom_range(0, 40) == 0);
      return s;
   endfunction

   logic [7:0] drained_q[$];

   task automatic run_to_done(input string tag);
      obs_t o;
      bit   seen = 0;
      for (int i = 0; i < 60 && !seen; i++) begin
         step(idle_s(1'b1), o);
         if (o.valid) drained_q.push_back(o.data);
         if (o.done) seen = 1;
      end
      chk(tag, 32'(seen), 32'd1);
   endtask

   vec_t tbl [14];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      obs_t  o;
      stim_t s;
      int    nsym, target, guard;
      logic [7:0] b;

      // reset
      s = idle_s(1'b0); s.rst = 1;
      step(s, o);
      step(s, o);
      step(idle_s(1'b0), o);

      // ---- table: basic frame, m_ready held high ----
      tbl[0]  = vv(st(1,0,0,2'd0,8'h00,8'h00,0,8'h00,1), 0,8'h00,0,0,0,0,0);
      tbl[1]  = vv(st(0,1,0,2'd1,8'h11,8'h00,0,8'h00,1), 0,8'h00,0,1,0,0,0);
      tbl[2]  = vv(st(0,1,0,2'd1,8'h22,8'h00,0,8'h00,1), 1,8'h11,0,0,0,0,0);
      tbl[3]  = vv(st(0,1,0,2'd1,8'h33,8'h00,0,8'h00,1), 1,8'h22,0,0,0,0,0);
      tbl[4]  = vv(st(0,0,1,2'd0,8'h00,8'h00,0,8'h00,1), 1,8'h33,0,0,0,0,0);
      tbl[5]  = vv(st(0,0,0,2'd0,8'h00,8'h00,0,8'h00,1), 0,8'h00,0,0,1,0,0);
      tbl[6]  = vv(st(0,0,0,2'd0,8'h00,8'h00,0,8'h00,1), 0,8'h00,0,0,0,1,0);
      tbl[7]  = vv(st(0,0,0,2'd2,8'hA0,8'hA1,1,8'hA2,1), 0,8'h00,0,0,0,0,0);
      tbl[8]  = vv(st(0,0,0,2'd0,8'h00,8'h00,0,8'h00,1), 1,8'hA0,0,0,0,0,0);
      tbl[9]  = vv(st(0,0,0,2'd0,8'h00,8'h00,0,8'h00,1), 1,8'hA1,0,0,0,0,0);
      tbl[10] = vv(st(0,0,0,2'd0,8'h00,8'h00,0,8'h00,1), 1,8'hA2,1,0,0,0,0);
      tbl[11] = vv(st(0,0,0,2'd0,8'h00,8'h00,0,8'h00,1), 0,8'h00,0,0,0,0,0);
      tbl[12] = vv(st(0,0,0,2'd0,8'h00,8'h00,0,8'h00,1), 0,8'h00,0,0,0,0,1);
      tbl[13] = vv(st(0,0,0,2'd0,8'h00,8'h00,0,8'h00,1), 0,8'h00,0,0,0,0,0);
      for (int i = 0; i < 14; i++) begin
         step(tbl[i].s, o);
         chk("tbl_valid", 32'(o.valid), 32'(tbl[i].e_valid));
         if (tbl[i].e_valid) chk("tbl_data", 32'(o.data), 32'(tbl[i].e_data));
         chk("tbl_last", 32'(o.last), 32'(tbl[i].e_last));
         chk("tbl_first", 32'(o.first), 32'(tbl[i].e_first));
         chk("tbl_f23", 32'(o.f23), 32'(tbl[i].e_f23));
         chk("tbl_final", 32'(o.fin), 32'(tbl[i].e_fin));
         chk("tbl_done", 32'(o.done), 32'(tbl[i].e_done));
      end

      // ---- overflow: sink blocked, 3 bytes per cycle ----
      s = idle_s(1'b0); s.start = 1; step(s, o);
      for (int i = 0; i < 5; i++) begin
         b = 8'(3 * i);
         step(push_s(2'd3, b, b + 8'd1, b + 8'd2, 1'b0), o);
         if (i == 4) chk("stall_at_12", 32'(o.stall), 32'd0);
      end
      step(push_s(2'd3, 8'd15, 8'hE1, 8'hE2, 1'b0), o);
      chk("stall_at_15", 32'(o.stall), 32'd1);
      step(push_s(2'd3, 8'hE3, 8'hE4, 8'hE5, 1'b0), o);
      chk("count_full", 32'(o.count), 32'd16);
      chk("ovf_set", 32'(o.ovf), 32'd1);
      s = idle_s(1'b0); s.fend = 1; step(s, o);
      step(idle_s(1'b0), o);
      step(idle_s(1'b0), o);
      s = idle_s(1'b0); s.flag_last = 1; s.lb = 8'hEE; step(s, o);
      drained_q.delete();
      run_to_done("ovf_done");
      chk("ovf_drain_len", 32'(drained_q.size()), 32'd16);
      foreach (drained_q[i]) chk("ovf_drain_byte", 32'(drained_q[i]), 32'(i));

      // ---- same-cycle push/pop, pointer wrap, timeout ----
      s = idle_s(1'b0); s.start = 1; step(s, o);
      step(push_s(2'd3, 8'h40, 8'h41, 8'h42, 1'b0), o);
      step(push_s(2'd2, 8'h43, 8'h44, 8'h00, 1'b0), o);
      step(push_s(2'd3, 8'h45, 8'h46, 8'h47, 1'b1), o);
      chk("pp_count_5", 32'(o.count), 32'd5);
      for (int i = 0; i < 12; i++) begin
         s = push_s(2'd1, 8'(8'h50 + i), 8'h00, 8'h00, 1'b1);
         s.carry = (i == 3);
         step(s, o);
         if (i == 0) chk("pp_count_7", 32'(o.count), 32'd7);
      end
      s = idle_s(1'b1); s.fend = 1; step(s, o);
      step(idle_s(1'b1), o);
      step(idle_s(1'b1), o);
      for (int i = 0; i < LT; i++) step(idle_s(1'b1), o);
      chk("tmo_not_early", 32'(o.tmo), 32'd0);
      step(idle_s(1'b1), o);
      chk("tmo_set", 32'(o.tmo), 32'd1);
      chk("carry_set", 32'(o.carry), 32'd1);
      run_to_done("tmo_done");

      // ---- reset in the middle of DRAIN ----
      s = idle_s(1'b0); s.start = 1; step(s, o);
      step(push_s(2'd3, 8'h70, 8'h71, 8'h72, 1'b0), o);
      s = push_s(2'd2, 8'h73, 8'h74, 8'h00, 1'b0); s.carry = 1; step(s, o);
      s = idle_s(1'b0); s.fend = 1; step(s, o);
      step(idle_s(1'b0), o);
      step(idle_s(1'b0), o);
      s = idle_s(1'b0); s.flag_last = 1; s.lb = 8'h75; step(s, o);
      step(idle_s(1'b0), o);
      chk("drain_count_6", 32'(o.count), 32'd6);
      s = idle_s(1'b0); s.rst = 1; step(s, o);
      step(idle_s(1'b0), o);
      chk("rst_valid", 32'(o.valid), 32'd0);
      chk("rst_count", 32'(o.count), 32'd0);
      chk("rst_carry", 32'(o.carry), 32'd0);

      // ---- randomized frames against the model ----
      for (int f = 0; f < 25; f++) begin
         s = idle_s(1'($urandom_range(0, 1))); s.start = 1; step(s, o);
         nsym = int'($urandom_range(1, 12));
         for (int i = 0; i < nsym; i++) begin
            s = rand_s();
            s.sym       = ($urandom_range(0, 3) != 0);
            s.fend      = (i == nsym - 1);
            s.flag_last = ($urandom_range(0, 30) == 0);
            s.start     = ($urandom_range(0, 20) == 0);
            step(s, o);
         end
         target = int'($urandom_range(0, 18));
         guard  = 0;
         while (ph != P_IDLE && guard < 300) begin
            s = rand_s();
            s.flag_last = (ph == P_WAIT) && (wait_cycles == target);
            step(s, o);
            guard++;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
